regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file; the next generation of the core register file.
//  - Configurable width, depth, read-port count and read latency.
//  - Optional hard-zero r0 and optional write-first bypass.
//  - Self-clearing: after reset or on request, a sequencer zeroes every entry.
//  Sits between decode (read addresses) and writeback (write port) in the pipeline.
// PARAMETERS
//  XLEN      32  data width in bits
//  NREGS     32  number of entries (>=2); localparam AW = $clog2(NREGS)
//  NREAD     2   number of read ports (1..4)
//  RD_LAT    2   read latency in clock edges (1 or 2)
//  ZERO_REG  1   1: entry 0 always reads 0 and writes to it are dropped
//  BYPASS    1   1: same-cycle write to a sampled read address is forwarded (write-first)
// PORTS
//  clk      in   1           rising-edge clock
//  rst_n    in   1           synchronous active-low reset
//  rd_addr  in   NREAD*AW    read addresses; port p = rd_addr[p*AW +: AW]
//  rd_data  out  NREAD*XLEN  read data; port p = rd_data[p*XLEN +: XLEN]
//  wr_en    in   1           write enable
//  wr_addr  in   AW          write address
//  wr_data  in   XLEN        write data
//  clr_req  in   1           request a full clear (single-cycle pulse, honoured only in IDLE)
//  busy     out  1           1 while a clear is in progress
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state<=CLEAR, clr_ptr<=0, busy<=1, all rd_data pipeline regs <=0.
//    Array contents are not reset directly; the CLEAR sequence zeroes them.
//  - FSM states: CLEAR, IDLE.
//    - CLEAR: each edge writes 0 to entry clr_ptr, then clr_ptr++.
//      After the edge that writes entry NREGS-1: state<=IDLE, busy<=0.
//      A clear takes exactly NREGS edges.
//    - IDLE: clr_req=1 -> state<=CLEAR, clr_ptr<=0, busy<=1 on that edge;
//      a write requested on that same edge is dropped.
//    - clr_req is ignored while in CLEAR. rst_n=0 mid-clear restarts the sequence at entry 0.
//  - Writes (IDLE only): at an edge with wr_en=1, entry wr_addr <= wr_data.
//    - Dropped if wr_addr>=NREGS, or if ZERO_REG=1 and wr_addr==0.
//    - wr_en is ignored entirely in CLEAR.
//  - Reads, stage 1: every edge, each port samples mem[rd_addr[p]].
//    - Result 0 if rd_addr>=NREGS, if ZERO_REG=1 and addr==0, or if state is CLEAR.
//    - BYPASS=1, IDLE, accepted write with wr_addr==rd_addr[p] at the same edge:
//      the sampled value is wr_data (new value).
//    - BYPASS=0 in the same situation: the sampled value is the old contents.
//  - Reads, latency:
//    - RD_LAT=1: the stage-1 register drives rd_data, valid 1 edge after the address is presented.
//    - RD_LAT=2: a second register stage follows, valid 2 edges after.
//    - Stage 2 holds a snapshot: writes after stage 1 do not alter data already in flight.
//  - Read ports are fully independent; any number of ports may share an address.
//  - Throughput: 1 read per port plus 1 write per cycle, no stalls except during CLEAR.
//  - No combinational path from any input to rd_data or busy.
// TESTING
//  1 Reset: rst_n=0 for 1 edge, release.
//    -> busy=1 for exactly NREGS edges then 0; reading every address afterwards returns 0.
//  2 Write/read, RD_LAT=2: write r5=32'hDEADBEEF, then present rd_addr[0]=5.
//    -> rd_data[0]=32'hDEADBEEF exactly 2 edges after the address edge.
//  3 r0: wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF; read r0 on ports 0 and 1 -> both return 0.
//  4 Bypass: same edge write r7=32'h1234 and sample rd_addr[1]=7.
//    -> BYPASS=1 returns 32'h1234; BYPASS=0 returns the prior value 0.
//  5 Clear mid-run: fill r1..r31 with their own index, pulse clr_req; wr_en=1 during CLEAR.
//    -> busy for 32 edges, writes dropped, all entries read 0 afterwards.
//  6 Reset mid-clear: assert rst_n=0 at clear step 10.
//    -> clr_ptr restarts at 0; busy lasts a full NREGS edges after release.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with self-clearing sequencer.
// Reads are registered in one or two stages; writes land in IDLE only.
// A CLEAR sequence zeroes one entry per edge after reset or on request.
//
//   state | meaning
//   CLEAR | sequencer zeroing entry clr_ptr_q each edge; writes ignored, reads return 0
//   IDLE  | normal operation; one write plus NREAD reads per edge
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NREAD    = 2,
  parameter  int RD_LAT   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  clr_req,
  output logic                  busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // One bit wider than an address so the range check also works for
  // depths that are not a power of two.
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS-1);

  state_e          state_q;
  logic [AW-1:0]   clr_ptr_q;
  logic            busy_q;
  logic [XLEN-1:0] mem_q   [NREGS];
  logic [AW-1:0]   ra      [NREAD];
  logic [XLEN-1:0] rd_s1_d [NREAD];
  logic [XLEN-1:0] rd_s1_q [NREAD];
  logic [XLEN-1:0] rd_out  [NREAD];
  logic            wr_ok;

  // Entry is addressable and not the hard-wired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // A write is dropped on the edge that starts a clear.
  assign wr_ok = (state_q == IDLE) && !clr_req && wr_en && addr_ok(wr_addr);

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    assign ra[p]                     = rd_addr[p*AW +: AW];
    assign rd_data[p*XLEN +: XLEN]   = rd_out[p];
  end

  // Clear sequencer and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= CLEAR;
          clr_ptr_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: cleared one entry per edge in CLEAR, written in IDLE.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  // Stage-1 read mux with optional write-first forwarding.
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      rd_s1_d[p] = '0;
      if ((state_q == IDLE) && addr_ok(ra[p])) begin
        if ((BYPASS != 0) && wr_ok && (wr_addr == ra[p])) begin
          rd_s1_d[p] = wr_data;
        end else begin
          rd_s1_d[p] = mem_q[ra[p]];
        end
      end
    end
  end

  // Stage-1 read registers.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NREAD; p++) begin
      if (!rst_n) begin
        rd_s1_q[p] <= '0;
      end else begin
        rd_s1_q[p] <= rd_s1_d[p];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [XLEN-1:0] rd_s2_q [NREAD];

    // Stage-2 snapshot of stage 1; later writes do not disturb it.
    always_ff @(posedge clk) begin
      for (int p = 0; p < NREAD; p++) begin
        if (!rst_n) begin
          rd_s2_q[p] <= '0;
        end else begin
          rd_s2_q[p] <= rd_s1_q[p];
        end
      end
    end

    assign rd_out = rd_s2_q;
  end else begin : g_lat1
    assign rd_out = rd_s1_q;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Two instances share stimulus:
// u_a uses the defaults (RD_LAT=2, BYPASS=1), u_b uses RD_LAT=1, BYPASS=0.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy_a)
  );

  regfile_mp #(.RD_LAT(1), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    set_rd(5'd0, 5'd0);
    tick();
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got a=%b b=%b want 1", busy_a, busy_b);
    end
    checks++;
    if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got a=%h b=%h want 0", rd_data_a, rd_data_b);
    end
    rst_n = 1'b1;
    count_busy(n);
    checks++;
    if (n != 32) begin
      errors++; $display("FAIL reset_busy_len: got %0d edges want 32", n);
    end
    checks++;
    if (busy_b !== 1'b0) begin
      errors++; $display("FAIL reset_busy_b: got %b want 0", busy_b);
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      tick();
      tick();
      checks++;
      if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
        errors++; $display("FAIL reset_read_r%0d: got a=%h b=%h want 0", a, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_write_read();
    set_rd(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    set_rd(5'd5, 5'd0);
    tick();
    checks++;
    if (rd_data_a[31:0] !== 32'h0) begin
      errors++; $display("FAIL wr_rd_lat2_early: got %h want 00000000", rd_data_a[31:0]);
    end
    checks++;
    if (rd_data_b[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_rd_lat1: got %h want deadbeef", rd_data_b[31:0]);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
    set_rd(5'd0, 5'd0);
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_data_a[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_rd_lat2: got %h want deadbeef", rd_data_a[31:0]);
    end
    set_rd(5'd5, 5'd5);
    tick();
    tick();
    checks++;
    if (rd_data_a !== {32'h11111111, 32'h11111111}) begin
      errors++; $display("FAIL wr_rd_overwrite: got %h want 1111111111111111", rd_data_a);
    end
  endtask

  task automatic test_r0();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0);
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_data_b !== 64'd0) begin
      errors++; $display("FAIL r0_lat1: got %h want 0", rd_data_b);
    end
    tick();
    checks++;
    if (rd_data_a !== 64'd0) begin
      errors++; $display("FAIL r0_bypass: got %h want 0", rd_data_a);
    end
    tick();
    checks++;
    if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
      errors++; $display("FAIL r0_stored: got a=%h b=%h want 0", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
    set_rd(5'd0, 5'd7);
    tick();
    wr_en = 1'b0;
    set_rd(5'd0, 5'd0);
    checks++;
    if (rd_data_b[63:32] !== 32'h0) begin
      errors++; $display("FAIL bypass_off_old: got %h want 00000000", rd_data_b[63:32]);
    end
    tick();
    checks++;
    if (rd_data_a[63:32] !== 32'h1234) begin
      errors++; $display("FAIL bypass_on_new: got %h want 00001234", rd_data_a[63:32]);
    end
    set_rd(5'd7, 5'd7);
    tick();
    checks++;
    if (rd_data_b !== {32'h1234, 32'h1234}) begin
      errors++; $display("FAIL bypass_stored_b: got %h want 0000123400001234", rd_data_b);
    end
    tick();
    checks++;
    if (rd_data_a !== {32'h1234, 32'h1234}) begin
      errors++; $display("FAIL bypass_stored_a: got %h want 0000123400001234", rd_data_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a, exp_b;
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) begin
        wr_en = 1'b1; wr_addr = 5'(10 + j); wr_data = 32'h100 + 32'(j);
        set_rd(5'(10 + j), 5'd0);
      end else begin
        wr_en = 1'b0;
      end
      tick();
      exp_b = (j < 4) ? 32'h0 : 32'h103;
      checks++;
      if (rd_data_b[31:0] !== exp_b) begin
        errors++; $display("FAIL b2b_lat1_e%0d: got %h want %h", j, rd_data_b[31:0], exp_b);
      end
      if (j >= 1) begin
        exp_a = 32'h100 + 32'(j - 1);
        checks++;
        if (rd_data_a[31:0] !== exp_a) begin
          errors++; $display("FAIL b2b_lat2_e%0d: got %h want %h", j, rd_data_a[31:0], exp_a);
        end
      end
    end
  endtask

  task automatic test_clear_midrun();
    int n;
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    set_rd(5'd31, 5'd17);
    tick();
    tick();
    checks++;
    if (rd_data_a !== {32'd17, 32'd31}) begin
      errors++; $display("FAIL clr_fill: got %h want 000000110000001f", rd_data_a);
    end
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA;
    tick();
    clr_req = 1'b0;
    wr_addr = 5'd1; wr_data = 32'hDEAD0001;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL clr_busy_start: got %b want 1", busy_a);
    end
    n = 0;
    while (busy_a && n < 200) begin
      tick();
      n++;
      if (n == 3) begin
        checks++;
        if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
          errors++; $display("FAIL clr_read_zero: got a=%h b=%h want 0", rd_data_a, rd_data_b);
        end
      end
      clr_req = (n == 5);
      wr_addr = (n > 20) ? 5'd31 : 5'd1;
    end
    clr_req = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (n != 32) begin
      errors++; $display("FAIL clr_busy_len: got %0d edges want 32", n);
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(a));
      tick();
      tick();
      checks++;
      if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
        errors++; $display("FAIL clr_read_r%0d: got a=%h b=%h want 0", a, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_reset_midclear();
    int n;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL rmc_busy_pre: got %b want 1", busy_a);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy_a !== 1'b1 || rd_data_a !== 64'd0) begin
      errors++; $display("FAIL rmc_reset_state: got busy=%b data=%h want 1/0", busy_a, rd_data_a);
    end
    count_busy(n);
    checks++;
    if (n != 32) begin
      errors++; $display("FAIL rmc_busy_len: got %0d edges want 32", n);
    end
    set_rd(5'd9, 5'd5);
    tick();
    tick();
    checks++;
    if (rd_data_a !== 64'd0) begin
      errors++; $display("FAIL rmc_read: got %h want 0", rd_data_a);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_back_to_back();
    test_clear_midrun();
    test_reset_midclear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
